// File: rtl/axi4_burst_manager.sv
// Single-outstanding AXI4 burst manager: one command becomes an AW/W/B or
// AR/R exchange on the manager port and ends in exactly one completion.
module axi4_burst_manager #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [1:0]          cmd_burst,

    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,

    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,

    output logic                done_valid,
    input  logic                done_ready,
    output logic [1:0]          done_resp,
    output logic                done_write,

    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,

    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,

    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,

    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,

    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);
    localparam int LSB = $clog2(DATA_W/8);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic              write_q;
    logic [8:0]        beat_cnt;
    logic [1:0]        worst_q, worst_nxt;
    logic              err_q;
    logic              last_beat;
    logic [31:0]       incr_end;
    logic              pre_fail;
    logic              cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, done_hs;

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign b_hs    = BVALID && BREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign r_hs    = RVALID && RREADY;
    assign done_hs = done_valid && done_ready;

    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign worst_nxt = (RRESP > worst_q) ? RRESP : worst_q;

    // Illegal commands are rejected before any AXI traffic is generated.
    always_comb begin
        incr_end = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << LSB);
        pre_fail = 1'b0;
        if (cmd_burst == 2'b11)
            pre_fail = 1'b1;
        if ((cmd_addr & ADDR_W'(DATA_W/8 - 1)) != '0)
            pre_fail = 1'b1;
        if (cmd_burst == 2'b01 && incr_end > 32'd4096)
            pre_fail = 1'b1;
        if (cmd_burst == 2'b10 && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            pre_fail = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_hs) state_nxt = pre_fail ? ST_DONE : (cmd_write ? ST_AW : ST_AR);
            ST_AW:   if (aw_hs) state_nxt = ST_W;
            ST_W:    if (w_hs && last_beat) state_nxt = ST_B;
            ST_B:    if (b_hs) state_nxt = ST_DONE;
            ST_AR:   if (ar_hs) state_nxt = ST_R;
            ST_R:    if (r_hs && RLAST) state_nxt = ST_DONE;
            ST_DONE: if (done_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        wd_ready   = 1'b0;
        BREADY     = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        rd_valid   = 1'b0;
        done_valid = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_AW:   AWVALID = 1'b1;
            ST_W: begin
                WVALID   = wd_valid;
                wd_ready = WREADY;
            end
            ST_B:    BREADY = 1'b1;
            ST_AR:   ARVALID = 1'b1;
            ST_R: begin
                rd_valid = RVALID;
                RREADY   = rd_ready;
            end
            ST_DONE: done_valid = 1'b1;
            default: ;
        endcase
    end

    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = 3'(LSB);
    assign AWBURST = burst_q;
    assign ARID    = id_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = 3'(LSB);
    assign ARBURST = burst_q;

    assign WDATA      = wd_data;
    assign WSTRB      = wd_strb;
    assign WLAST      = (state == ST_W) && last_beat;
    assign rd_data    = RDATA;
    assign rd_last    = RLAST;
    assign done_write = write_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            write_q   <= 1'b0;
            beat_cnt  <= '0;
            worst_q   <= '0;
            err_q     <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: if (cmd_hs) begin
                    id_q      <= cmd_id;
                    addr_q    <= cmd_addr;
                    len_q     <= cmd_len;
                    burst_q   <= cmd_burst;
                    write_q   <= cmd_write;
                    beat_cnt  <= '0;
                    worst_q   <= '0;
                    err_q     <= 1'b0;
                    done_resp <= pre_fail ? 2'b10 : 2'b00;
                end
                ST_W: if (w_hs) beat_cnt <= beat_cnt + 9'd1;
                ST_B: if (b_hs) done_resp <= (BID != id_q) ? 2'b10 : BRESP;
                ST_R: if (r_hs) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    worst_q  <= worst_nxt;
                    // Overrun past len is an error, but beats are drained until RLAST.
                    if (RID != id_q || (last_beat && !RLAST))
                        err_q <= 1'b1;
                    if (RLAST)
                        done_resp <= (!last_beat || err_q || RID != id_q) ? 2'b10 : worst_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/axi4_burst_manager.md
AXI4_BURST_MANAGER -- requirements
Module: axi4_burst_manager

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 64, data width in bits, a power of 2 and at least 8; ID_W, default 4, ID width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-low (ACLK, ARESETn).
REQ-003 Clock and reset ports SHALL be: ACLK in 1 clock; ARESETn in 1 sync active-low reset.
REQ-004 Command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1 = write); cmd_id in ID_W; cmd_addr in ADDR_W; cmd_len in 8 (beats-1); cmd_burst in 2.
REQ-005 Write-data stream ports SHALL be: wd_valid in 1; wd_ready out 1; wd_data in DATA_W; wd_strb in DATA_W/8.
REQ-006 Read-data stream ports SHALL be: rd_valid out 1; rd_ready in 1; rd_data out DATA_W; rd_last out 1.
REQ-007 Completion ports SHALL be: done_valid out 1; done_ready in 1; done_resp out 2; done_write out 1.
REQ-008 AXI4 manager ports SHALL be: AW*(ID,ADDR,LEN,SIZE,BURST,VALID out; READY in); W*(DATA,STRB,LAST,VALID out; READY in); B*(ID,RESP,VALID in; READY out); AR*(ID,ADDR,LEN,SIZE,BURST,VALID out; READY in); R*(ID,DATA,RESP,LAST,VALID in; READY out); widths per parameters.

Function
REQ-009 The block SHALL have at most one transaction outstanding, tracked by FSM states IDLE, AW, W, B, AR, R, DONE.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a cmd handshake SHALL latch id/addr/len/burst/write and move the FSM to AW (write), AR (read), or DONE (pre-check fail).
REQ-011 The pre-check SHALL fail when cmd_burst==2'b11, or cmd_addr[LSB-1:0]!=0, or burst==INCR and addr[11:0]+((len+1)<<LSB)>4096, or burst==WRAP and len+1 is not in {2,4,8,16}; on failure no AXI traffic SHALL occur and done_resp SHALL be 2'b10.
REQ-012 AxSIZE SHALL always be $clog2(DATA_W/8); AxID/AxADDR/AxLEN/AxBURST SHALL be driven from the latched command.
REQ-013 In AW, AWVALID SHALL be 1 and held with stable payload until AWREADY; the handshake SHALL move the FSM to W; no W beat SHALL precede the AW handshake.
REQ-014 In W, WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB=wd_data/wd_strb (combinational pass-through), and a 9-bit beat counter SHALL increment per W handshake.
REQ-015 WLAST SHALL be 1 exactly when beat count==len; the last handshake SHALL move the FSM to B.
REQ-016 In B, BREADY SHALL be 1; a B handshake SHALL set done_resp=BRESP, or 2'b10 if BID!=latched id, then move to DONE.
REQ-017 AR SHALL follow the AW rules with ARVALID/ARREADY and move to R.
REQ-018 In R, rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=RLAST (pass-through).
REQ-019 Each R handshake SHALL fold RRESP into a sticky worst response (numerically maximum) and SHALL mark an error if RID!=latched id.
REQ-020 The R handshake with RLAST=1 SHALL end the burst; done_resp SHALL be 2'b10 if the beat count!=len or an ID error was marked, else the worst RRESP.
REQ-021 A beat handshake at count==len with RLAST=0 SHALL set the error flag; the block SHALL keep accepting beats until RLAST.
REQ-022 In DONE, done_valid SHALL be 1 with done_resp/done_write stable until done_ready; the handshake SHALL return the FSM to IDLE, and cmd_ready SHALL rise the next cycle.
REQ-023 Outside its own state, every VALID/READY output SHALL be 0 (AWVALID, WVALID, BREADY, ARVALID, RREADY, wd_ready, rd_valid, cmd_ready, done_valid).
REQ-024 len=0 SHALL produce a single beat with WLAST=1, or a single expected R beat with RLAST.
REQ-025 Responses arriving while no matching channel is active (e.g. BVALID in IDLE) SHALL be ignored, since READY is 0.

Reset
REQ-026 On ACLK rising edge with ARESETn=0: FSM=IDLE; counters, latched fields, error/worst-resp flags=0; done_resp=2'b00.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no completion and SHALL drop all VALID/READY outputs in the following cycle.

Verification
REQ-028 Scenario: write INCR, addr 0x100, len 3, AWREADY delayed 2 cycles -> AWADDR=0x100, AWLEN=3, AWSIZE=3; 4 W beats, WLAST on the 4th; BRESP=00 -> done_resp=00, done_write=1.
REQ-029 Scenario: read WRAP, addr 0x38, len 3, RLAST on beat 4, RRESP 00,10,00,00 -> 4 rd beats, done_resp=10.
REQ-030 Scenario: INCR addr 0xFF8, len 1 -> no AWVALID asserted, done_resp=10 within 2 cycles of cmd handshake.
REQ-031 Scenario: read len 3 with RLAST on beat 2 -> FSM ends at beat 2, done_resp=10.
REQ-032 Scenario: BID=5 for cmd_id=3 -> done_resp=10; done_ready held low 5 cycles -> done_valid held, cmd_ready=0 throughout.
REQ-033 Scenario: ARESETn low during W beat 2 of 4 -> next cycle all VALIDs 0, FSM IDLE, cmd_ready=1 after reset release.
